// File: rtl/sd_cmd_resp_read.sv
// sd_cmd_resp_read
//   Receive side of the SD CMD line. Once armed by the command FSM it waits
//   for the card's start bit. It then shifts in a 48-bit (R1/R3/R6/R7) or
//   136-bit (R2) response MSB-first. On the way it runs the CRC7
//   (x^7 + x^3 + 1) over the protected bits. When the end bit arrives it
//   reports the decoded fields and the CRC, transmission-bit and end-bit
//   errors. If the card never drives a start bit, it flags an NCR timeout.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous reset, active-high
//   sd_strb_i    sample strobe; cmd_i is only looked at when this is 1
//   cmd_i        serial CMD line from the card (already synchronised)
//   start_i      1-cycle arm pulse, accepted only while idle
//   long_i       latched at start_i: 1 = 136-bit R2, 0 = 48-bit response
//   crc_chk_i    latched at start_i: 0 = do not report CRC errors (R3)
//   busy_o       high while waiting for / receiving a response
//   done_o       1-cycle pulse when a response completes or times out
//   resp_o       long: frame[127:0]; short: {96'b0, frame[39:8]}
//   cmd_idx_o    short: frame[45:40]; long: frame[133:128]
//   crc_err_o    received CRC7 differs from the computed one
//   frame_err_o  transmission bit was 1 or end bit was 0
//   timeout_o    no start bit within NCR_MAX strobes
module sd_cmd_resp_read #(
  parameter int NCR_MAX = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         sd_strb_i,
  input  logic         cmd_i,
  input  logic         start_i,
  input  logic         long_i,
  input  logic         crc_chk_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] resp_o,
  output logic [5:0]   cmd_idx_o,
  output logic         crc_err_o,
  output logic         frame_err_o,
  output logic         timeout_o
);

  localparam int CNT_W = $clog2(NCR_MAX + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    RECV       = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             long_reg;
  logic             crc_chk_reg;
  logic [7:0]       bit_idx_reg;   // index of the next bit expected on cmd_i
  logic [CNT_W-1:0] ncr_cnt_reg;
  logic [6:0]       crc_reg;
  // The start bit is always 0 and is never reported, so only frame bits
  // below it are kept. Bit 0 of the frame is cmd_i itself on the last strobe.
  logic [133:0]     shift_reg;

  logic [134:0]     frame_next;
  logic [7:0]       cur_idx;
  logic             crc_en;
  logic [6:0]       crc_step;
  logic             ncr_last;

  assign frame_next = {shift_reg, cmd_i};
  assign ncr_last   = (ncr_cnt_reg == CNT_W'(NCR_MAX - 1));

  // CRC coverage: short frames protect 47..8 (start bit included), R2
  // frames protect only 127..8, so the header byte leaves the CRC alone.
  always_comb begin
    cur_idx = bit_idx_reg;
    if (state_reg == WAIT_START) begin
      cur_idx = long_reg ? 8'd135 : 8'd47;
    end
    crc_en   = (cur_idx >= 8'd8) && (cur_idx <= (long_reg ? 8'd127 : 8'd47));
    crc_step = {crc_reg[5:0], 1'b0} ^ ((cmd_i ^ crc_reg[6]) ? 7'h09 : 7'h00);
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) state_next = WAIT_START;
      end
      WAIT_START: begin
        if (sd_strb_i) begin
          if (!cmd_i) begin
            state_next = RECV;
          end else if (ncr_last) begin
            state_next = DONE;
          end
        end
      end
      RECV: begin
        if (sd_strb_i && (bit_idx_reg == 8'd0)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state
  always_comb begin
    busy_o = (state_reg == WAIT_START) || (state_reg == RECV);
    done_o = (state_reg == DONE);
  end

  // Datapath and result registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      long_reg    <= 1'b0;
      crc_chk_reg <= 1'b0;
      bit_idx_reg <= 8'd0;
      ncr_cnt_reg <= '0;
      crc_reg     <= 7'd0;
      shift_reg   <= '0;
      resp_o      <= 128'd0;
      cmd_idx_o   <= 6'd0;
      crc_err_o   <= 1'b0;
      frame_err_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            long_reg    <= long_i;
            crc_chk_reg <= crc_chk_i;
            ncr_cnt_reg <= '0;
            crc_reg     <= 7'd0;
            shift_reg   <= '0;
            resp_o      <= 128'd0;
            cmd_idx_o   <= 6'd0;
            crc_err_o   <= 1'b0;
            frame_err_o <= 1'b0;
            timeout_o   <= 1'b0;
          end
        end
        WAIT_START: begin
          if (sd_strb_i) begin
            if (!cmd_i) begin
              // Start bit is 0 and the shift register is already clear,
              // so only the CRC needs the bit.
              if (crc_en) crc_reg <= crc_step;
              bit_idx_reg <= long_reg ? 8'd134 : 8'd46;
            end else begin
              ncr_cnt_reg <= ncr_cnt_reg + 1'b1;
              if (ncr_last) timeout_o <= 1'b1;
            end
          end
        end
        RECV: begin
          if (sd_strb_i) begin
            shift_reg <= frame_next[133:0];
            if (crc_en) crc_reg <= crc_step;
            if (bit_idx_reg == 8'd0) begin
              // CRC bits 7..1 and the end bit are outside coverage, so
              // crc_reg already holds the final value here.
              if (long_reg) begin
                resp_o      <= frame_next[127:0];
                cmd_idx_o   <= frame_next[133:128];
                frame_err_o <= frame_next[134] | ~frame_next[0];
              end else begin
                resp_o      <= {96'd0, frame_next[39:8]};
                cmd_idx_o   <= frame_next[45:40];
                frame_err_o <= frame_next[46] | ~frame_next[0];
              end
              crc_err_o <= crc_chk_reg && (crc_reg != frame_next[7:1]);
            end else begin
              bit_idx_reg <= bit_idx_reg - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_resp_read.sv
// Scoreboard bench for sd_cmd_resp_read. The stimulus side pushes the
// expected result of each response into a queue. That result comes from a
// CRC computed by polynomial long division plus plain field slicing. A
// monitor pops the queue whenever done_o pulses and compares all the fields.
module tb_sd_cmd_resp_read;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         sd_strb_i;
  logic         cmd_i;
  logic         start_i;
  logic         long_i;
  logic         crc_chk_i;
  logic         busy_o;
  logic         done_o;
  logic [127:0] resp_o;
  logic [5:0]   cmd_idx_o;
  logic         crc_err_o;
  logic         frame_err_o;
  logic         timeout_o;

  always #5 clk_i = ~clk_i;

  sd_cmd_resp_read #(.NCR_MAX(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sd_strb_i(sd_strb_i), .cmd_i(cmd_i),
    .start_i(start_i), .long_i(long_i), .crc_chk_i(crc_chk_i),
    .busy_o(busy_o), .done_o(done_o), .resp_o(resp_o), .cmd_idx_o(cmd_idx_o),
    .crc_err_o(crc_err_o), .frame_err_o(frame_err_o), .timeout_o(timeout_o)
  );

  typedef struct packed {
    logic [127:0] resp;
    logic [5:0]   idx;
    logic         crc_err;
    logic         frame_err;
    logic         timeout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic [135:0] f, input bit lg);
    bit         d[0:127];
    int         hi = lg ? 127 : 47;
    int         n  = hi - 7;
    logic [7:0] g  = 8'h89;
    logic [6:0] r;
    for (int i = 0; i < n; i++) d[i] = f[hi - i];
    for (int i = n; i < n + 7; i++) d[i] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (d[i]) begin
        for (int k = 0; k < 8; k++) d[i + k] = d[i + k] ^ g[7 - k];
      end
    end
    for (int k = 0; k < 7; k++) r[6 - k] = d[n + k];
    return r;
  endfunction

  function automatic exp_t model(input logic [135:0] f, input bit lg, input bit ck);
    exp_t e;
    e.timeout = 1'b0;
    if (lg) begin
      e.resp      = f[127:0];
      e.idx       = f[133:128];
      e.frame_err = f[134] | ~f[0];
    end else begin
      e.resp      = {96'd0, f[39:8]};
      e.idx       = f[45:40];
      e.frame_err = f[46] | ~f[0];
    end
    e.crc_err = ck && (crc7_div(f, lg) != f[7:1]);
    return e;
  endfunction

  function automatic logic [135:0] rand_frame(input bit lg);
    logic [135:0] f = '0;
    for (int i = 0; i < 4; i++) f[i*32 +: 32] = $urandom;
    f[135:128] = 8'($urandom);
    if (lg) begin
      f[135]     = 1'b0;
      f[134]     = ($urandom_range(9, 0) == 0);
      f[133:128] = 6'h3F;
    end else begin
      f[135:47] = '0;
      f[46]     = ($urandom_range(9, 0) == 0);
    end
    if ($urandom_range(4, 0) != 0) f[7:1] = crc7_div(f, lg);
    f[0] = ($urandom_range(9, 0) != 0);
    return f;
  endfunction

  // One cycle of stimulus, applied just after the rising edge.
  task automatic drive(input logic strb, input logic cmd, input logic st,
                       input logic lg, input logic ck);
    @(posedge clk_i);
    #1;
    sd_strb_i = strb;
    cmd_i     = cmd;
    start_i   = st;
    long_i    = lg;
    crc_chk_i = ck;
  endtask

  // Non-strobe cycles with junk on cmd_i and occasional stray start_i pulses.
  task automatic gaps(input int gmin, input int gmax, input bit lg, input bit ck);
    int g = $urandom_range(gmax, gmin);
    repeat (g) begin
      bit s = ($urandom_range(7, 0) == 0);
      drive(1'b0, 1'($urandom), s, s ? ~lg : lg, s ? ~ck : ck);
    end
  endtask

  // Sends the first nbits of frame f (all of it when nbits = N).
  task automatic send_frame(input logic [135:0] f, input bit lg, input bit ck,
                            input int ncr, input int gmin, input int gmax, input int nbits);
    int n    = lg ? 136 : 48;
    bit full = (nbits >= n);
    if (full) exp_q.push_back(model(f, lg, ck));
    drive(1'b1, 1'b0, 1'b1, lg, ck);   // strobe during start_i must be ignored
    drive(1'b0, 1'b1, 1'b0, lg, ck);
    check("busy_after_start", 128'(busy_o), 128'd1);
    repeat (ncr) begin
      gaps(gmin, gmax, lg, ck);
      drive(1'b1, 1'b1, 1'b0, lg, ck);
    end
    for (int i = n - 1; i >= n - nbits; i--) begin
      gaps(gmin, gmax, lg, ck);
      drive(1'b1, f[i], 1'b0, lg, ck);
    end
    if (full) begin
      drive(1'b0, 1'b1, 1'b0, lg, ck);
      check("done_latency", 128'(done_o), 128'd1);
      check("busy_at_done", 128'(busy_o), 128'd0);
      drive(1'b0, 1'b1, 1'b0, lg, ck);
      check("done_one_cycle", 128'(done_o), 128'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, 128'(done_o), 128'd0);
    check({tag, "_busy"}, 128'(busy_o), 128'd0);
    check({tag, "_resp"}, resp_o, 128'd0);
    check({tag, "_idx"}, 128'(cmd_idx_o), 128'd0);
    check({tag, "_crc_err"}, 128'(crc_err_o), 128'd0);
    check({tag, "_frame_err"}, 128'(frame_err_o), 128'd0);
    check({tag, "_timeout"}, 128'(timeout_o), 128'd0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 required no pending response");
      end else begin
        e = exp_q.pop_front();
        txn++;
        check("resp", resp_o, e.resp);
        check("cmd_idx", 128'(cmd_idx_o), 128'(e.idx));
        check("crc_err", 128'(crc_err_o), 128'(e.crc_err));
        check("frame_err", 128'(frame_err_o), 128'(e.frame_err));
        check("timeout", 128'(timeout_o), 128'(e.timeout));
        $display("txn %0d: cmd_idx=%h resp=%h crc_err=%b frame_err=%b timeout=%b",
                 txn, cmd_idx_o, resp_o, crc_err_o, frame_err_o, timeout_o);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish required finish before 600000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [135:0] f;
    bit           lg;
    bit           ck;
    exp_t         e;

    rst_i = 1'b1; sd_strb_i = 1'b0; cmd_i = 1'b1; start_i = 1'b0;
    long_i = 1'b0; crc_chk_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_i = 1'b0;

    // Spec vectors
    send_frame(136'(48'h08_000001AA_13), 1'b0, 1'b1, 2, 0, 0, 48);
    send_frame(136'(48'h08_000001AB_13), 1'b0, 1'b1, 0, 0, 0, 48);

    // NCR timeout: the 63rd high strobe must not end it, the 64th must.
    e = '0;
    e.timeout = 1'b1;
    exp_q.push_back(e);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (63) begin
      gaps(0, 2, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("no_timeout_at_63", 128'(done_o), 128'd0);
    check("busy_at_63", 128'(busy_o), 128'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("timeout_done", 128'(done_o), 128'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    send_frame(136'(48'h3F_80FF8000_FF), 1'b0, 1'b0, 5, 0, 1, 48);
    send_frame(136'(48'h08_000001AA_12), 1'b0, 1'b1, 63, 0, 0, 48);
    send_frame(136'(48'h48_000001AA_13), 1'b0, 1'b1, 1, 0, 0, 48);

    // Reset mid-frame, strobe every 4th cycle, then a clean R7.
    send_frame(136'(48'h08_000001AA_13), 1'b0, 1'b1, 0, 3, 3, 20);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("midframe_reset");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    rst_i = 1'b0;
    send_frame(136'(48'h08_000001AA_13), 1'b0, 1'b1, 0, 3, 3, 48);

    // Randomised short and long responses
    repeat (24) begin
      lg = 1'($urandom);
      ck = ($urandom_range(3, 0) != 0);
      f  = rand_frame(lg);
      send_frame(f, lg, ck, $urandom_range(63, 0), 0, 3, lg ? 136 : 48);
    end

    repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("queue_empty", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
